// File: rtl/fifo_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_arbiter_if
// Bundle of the read-port arbiter's handshake and data signals.
//   req       consumer -> arbiter   per-consumer read request (level)
//   rempty    fifo     -> arbiter   FIFO empty flag
//   rdata     fifo     -> arbiter   FIFO head word
//   rinc      arbiter  -> fifo      pop strobe
//   gnt       arbiter  -> consumer  one-hot grant
//   dout      arbiter  -> consumer  popped word
//   dout_vld  arbiter  -> consumer  popped word valid pulse
//   dout_id   arbiter  -> consumer  index of the consumer owning dout
// Modport slave is the arbiter side, master is the FIFO/consumer side.
// -----------------------------------------------------------------------------
interface fifo_rd_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]  req;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic [DSIZE-1:0] dout;
  logic             dout_vld;
  logic [IDW-1:0]   dout_id;

  modport slave (
    input  req, rempty, rdata,
    output rinc, gnt, dout, dout_vld, dout_id
  );

  modport master (
    output req, rempty, rdata,
    input  rinc, gnt, dout, dout_vld, dout_id
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rd_arbiter
// Shares the single read port of the async FIFO's read domain between NREQ
// consumers. One consumer is granted at a time in round-robin order; while
// granted and the FIFO is non-empty, the head word is popped every cycle and
// returned one cycle later with a valid pulse and the consumer index.
//
// Ports:
//   i_rclk  read-domain clock, rising edge
//   i_rrst  asynchronous active-high reset
//   bus     fifo_rd_arbiter_if.slave (req, rempty, rdata in;
//           rinc, gnt, dout, dout_vld, dout_id out)
//
// Build option: RDARB_BURST_LIMIT_EN - when defined, a grant ends after BURST
// pops. When undefined, a grant lasts until the owner drops req or the FIFO
// empties, and BURST has no effect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant; arbitrate among requesters when FIFO is non-empty
// S_SERVE | one consumer owns the read port; pop while req & ~rempty
// -----------------------------------------------------------------------------
module fifo_rd_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic              i_rclk,
  input  logic              i_rrst,
  fifo_rd_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_last;
  logic [DSIZE-1:0] r_dout;
  logic             r_dout_vld;
  logic [IDW-1:0]   r_dout_id;

  logic [IDW:0]     w_idx;
  logic [IDW-1:0]   w_sel;
  logic             w_found;
  logic             w_start;
  logic             w_pop;
  logic             w_burst_end;
  logic             w_exit;
  logic             w_rinc;

  // Round-robin search starting just after the most recent winner. The extra
  // bit in w_idx holds last+i before the modulo fold, so non-power-of-two
  // NREQ wraps correctly.
  always_comb begin
    w_sel   = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = {1'b0, r_last} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (!w_found && bus.req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_start = (r_state == S_IDLE) && w_found && !bus.rempty;
  assign w_pop   = (r_state == S_SERVE) && bus.req[r_owner] && !bus.rempty;

`ifdef RDARB_BURST_LIMIT_EN
  logic [7:0] r_count;

  // Only an actual pop can end a burst; an empty FIFO on the last slot
  // leaves the count untouched and exits through the rempty term instead.
  assign w_burst_end = w_pop && (r_count == 8'(BURST - 1));

  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst)       r_count <= '0;
    else if (w_start) r_count <= '0;
    else if (w_pop)   r_count <= r_count + 8'd1;
  end
`else
  assign w_burst_end = 1'b0;
`endif

  assign w_exit = (r_state == S_SERVE) &&
                  (!bus.req[r_owner] || bus.rempty || w_burst_end);

  always_comb begin
    w_state_nxt = r_state;
    w_rinc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        w_rinc = w_pop;
        if (w_exit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rclk or posedge i_rrst) begin
    if (i_rrst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_dout_id  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dout_vld <= w_pop;
      if (w_start) begin
        r_gnt   <= NREQ'(1) << w_sel;
        r_owner <= w_sel;
        r_last  <= w_sel;
      end else if (w_exit) begin
        r_gnt   <= '0;
      end
      if (w_pop) begin
        r_dout    <= bus.rdata;
        r_dout_id <= r_owner;
      end
    end
  end

  // BURST is only consumed by the burst-limit build; flag nonsense values
  // in every build so a bad override is visible in the hierarchy.
  if (BURST < 1 || BURST > 255 || NREQ < 2) begin : g_param_out_of_range
  end

  assign bus.rinc     = w_rinc;
  assign bus.gnt      = r_gnt;
  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.dout_id  = r_dout_id;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic clk  = 1'b0;
  logic rrst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_rd_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .i_rclk (clk),
    .i_rrst (rrst),
    .bus    (bus.slave)
  );

  // FIFO model: circular buffer, popped by the DUT's rinc, filled by tasks.
  logic [7:0] mem [0:255];
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] wr_ptr = 8'd0;
  assign bus.rempty = (rd_ptr == wr_ptr);
  assign bus.rdata  = mem[rd_ptr];
  always @(posedge clk) if (bus.rinc === 1'b1) rd_ptr <= rd_ptr + 8'd1;

  // Output log of popped words.
  logic [1:0] id_q  [$];
  logic [7:0] dat_q [$];
  always @(negedge clk) if (bus.dout_vld === 1'b1) begin
    id_q.push_back(bus.dout_id);
    dat_q.push_back(bus.dout);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) push(base + 8'(i));
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic clr_log();
    id_q.delete();
    dat_q.delete();
  endtask

  task automatic reset_pulse();
    @(negedge clk) rrst = 1'b1;
    @(negedge clk) rrst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0;
    rrst    = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.gnt, bus.rinc, bus.dout_vld} !== 6'b0) $display("FAIL reset_ctl: gnt/rinc/vld=%b want 0", {bus.gnt, bus.rinc, bus.dout_vld});
    else n_pass++;
    n_checks++;
    if ({bus.dout, bus.dout_id} !== 10'b0) $display("FAIL reset_data: dout=%h id=%0d want 0", bus.dout, bus.dout_id);
    else n_pass++;
    rrst = 1'b0;
    // Mid-burst reset with 3 words still queued.
    load(5, 8'h50);
    bus.req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001) $display("FAIL reset_pre_gnt: gnt=%b want 0001", bus.gnt);
    else n_pass++;
    repeat (2) @(negedge clk);
    #2 rrst = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt, bus.rinc, bus.dout_vld} !== 6'b0) $display("FAIL reset_async: gnt/rinc/vld=%b want 0", {bus.gnt, bus.rinc, bus.dout_vld});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (8'(wr_ptr - rd_ptr) !== 8'd3) $display("FAIL reset_no_pop: left=%0d want 3", 8'(wr_ptr - rd_ptr));
    else n_pass++;
    rrst    = 1'b0;
    bus.req = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001) $display("FAIL reset_regrant: gnt=%b want 0001", bus.gnt);
    else n_pass++;
    bus.req = '0;
    repeat (2) @(negedge clk);
    flush();
  endtask

  task automatic test_single();
    reset_pulse();
    flush();
    clr_log();
    push(8'h11); push(8'h22); push(8'h33);
    bus.req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.rinc !== 1'b1 || bus.dout_vld !== 1'b0)
      $display("FAIL single_grant: gnt=%b rinc=%b vld=%b want 0001/1/0", bus.gnt, bus.rinc, bus.dout_vld);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rinc !== 1'b1) $display("FAIL single_rinc%0d: rinc=%b want 1", k + 1, bus.rinc);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.rinc !== 1'b0 || bus.gnt !== 4'b0001) $display("FAIL single_empty: rinc=%b gnt=%b want 0/0001", bus.rinc, bus.gnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0000 || bus.rinc !== 1'b0) $display("FAIL single_idle: gnt=%b rinc=%b want 0000/0", bus.gnt, bus.rinc);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dat_q.size() != 3) $display("FAIL single_count: words=%0d want 3", dat_q.size());
    else if ({id_q[0], dat_q[0], id_q[1], dat_q[1], id_q[2], dat_q[2]} !== {2'd0, 8'h11, 2'd0, 8'h22, 2'd0, 8'h33})
      $display("FAIL single_data: got %h %h %h want 11 22 33 id 0", dat_q[0], dat_q[1], dat_q[2]);
    else n_pass++;
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_k;
    int t;
    reset_pulse();
    flush();
    load(200, 8'h00);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_k = g % NREQ;
      t = 0;
      @(negedge clk);
      while (bus.gnt === 4'b0000 && t < 10) begin
        @(negedge clk);
        t++;
      end
      n_checks++;
      if (bus.gnt !== (4'b0001 << exp_k)) $display("FAIL rr_order%0d: gnt=%b want %b", g, bus.gnt, 4'b0001 << exp_k);
      else n_pass++;
      @(negedge clk);
      bus.req[exp_k] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000) $display("FAIL rr_gap%0d: gnt=%b want 0000", g, bus.gnt);
      else n_pass++;
      bus.req[exp_k] = 1'b1;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    flush();
  endtask

  task automatic test_burst();
    int t;
    logic [1:0] exp_id;
    reset_pulse();
    flush();
    clr_log();
    load(10, 8'hA0);
    bus.req = 4'b0011;
    t = 0;
    while (dat_q.size() < 10 && t < 80) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (dat_q.size() != 10) $display("FAIL burst_count: words=%0d want 10", dat_q.size());
    else n_pass++;
    for (int i = 0; i < 10 && i < dat_q.size(); i++) begin
`ifdef RDARB_BURST_LIMIT_EN
      exp_id = (i < 4) ? 2'd0 : (i < 8) ? 2'd1 : 2'd0;
`else
      exp_id = 2'd0;
`endif
      n_checks++;
      if (id_q[i] !== exp_id || dat_q[i] !== 8'hA0 + 8'(i))
        $display("FAIL burst_word%0d: id=%0d data=%h want id=%0d data=%h", i, id_q[i], dat_q[i], exp_id, 8'hA0 + 8'(i));
      else n_pass++;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    flush();
  endtask

  task automatic test_req_drop();
    flush();
    clr_log();
    load(7, 8'h70);
    bus.req = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0010 || bus.rinc !== 1'b1) $display("FAIL drop_grant: gnt=%b rinc=%b want 0010/1", bus.gnt, bus.rinc);
    else n_pass++;
    repeat (2) @(negedge clk);
    bus.req = '0;
    #1;
    n_checks++;
    if (bus.rinc !== 1'b0 || bus.gnt !== 4'b0010) $display("FAIL drop_rinc: rinc=%b gnt=%b want 0/0010", bus.rinc, bus.gnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0000) $display("FAIL drop_gnt: gnt=%b want 0000", bus.gnt);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dat_q.size() != 2 || 8'(wr_ptr - rd_ptr) !== 8'd5)
      $display("FAIL drop_pulses: pulses=%0d left=%0d want 2/5", dat_q.size(), 8'(wr_ptr - rd_ptr));
    else n_pass++;
    n_checks++;
    if (dat_q.size() == 2 && {id_q[0], dat_q[0], id_q[1], dat_q[1]} !== {2'd1, 8'h70, 2'd1, 8'h71})
      $display("FAIL drop_data: got %0d:%h %0d:%h want 1:70 1:71", id_q[0], dat_q[0], id_q[1], dat_q[1]);
    else n_pass++;
    flush();
  endtask

  task automatic test_empty_gating();
    flush();
    bus.req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.rinc !== 1'b0) $display("FAIL empty_hold%0d: gnt=%b rinc=%b want 0000/0", c, bus.gnt, bus.rinc);
      else n_pass++;
    end
    load(2, 8'hE0);
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0100) $display("FAIL empty_release: gnt=%b want 0100", bus.gnt);
    else n_pass++;
    bus.req = '0;
    repeat (2) @(negedge clk);
    flush();
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_req_drop();
    test_empty_gating();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-port arbiter for the asynchronous FIFO. It shares the single read port of the read domain between NREQ consumers on the same read clock. It grants one consumer at a time in round-robin order and drives the FIFO pop strobe while the FIFO is non-empty. Each popped word is returned with a valid flag and the consumer's index.

## Interface
Parameters:
- NREQ, 4, number of consumers (2..16)
- DSIZE, 8, FIFO data width
- BURST, 4, max pops per grant when burst limiting is compiled in (1..255)

Ports:
- rclk  in  1  read-domain clock; all logic on rising edge
- rrst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-consumer read request, level; held while the consumer wants data
- rempty  in  1  FIFO empty flag from the read domain
- rdata  in  DSIZE  FIFO head word; valid combinationally whenever rempty=0
- rinc  out  1  pop strobe to the read domain; one word per cycle high
- gnt  out  NREQ  one-hot grant, registered; all-zero when idle
- dout  out  DSIZE  popped word, registered
- dout_vld  out  1  dout valid, one-cycle pulse per popped word
- dout_id  out  $clog2(NREQ)  index of the consumer dout belongs to

## Operation
- State machine: IDLE, SERVE.
- Registers: state, gnt, owner id, last id, pop count (8 bits), dout, dout_vld, dout_id.
- Reset values (rrst=1, immediate): state=IDLE, gnt=0, owner=0, last=NREQ-1, count=0, dout=0, dout_vld=0, dout_id=0. rinc=0 because it is derived from state.
- IDLE:
  - If any req bit is set and rempty=0, select the first set req bit searching from last+1 upward, modulo NREQ.
  - Register gnt=onehot(sel), owner=sel, last=sel, count=0, and go to SERVE.
  - Otherwise remain in IDLE with gnt=0.
- SERVE:
  - rinc = req[owner] & ~rempty. This is combinational from registered state and live inputs.
  - On each rinc cycle: dout<=rdata, dout_id<=owner, dout_vld<=1, count<=count+1.
  - On cycles with no pop: dout_vld<=0.
- SERVE exits to IDLE at the clock edge, and gnt clears at that edge, when any of the following holds:
  - req[owner]=0
  - rempty=1
  - a pop occurs with count==BURST-1 (burst limiting only)
- A pop may occur on the exit cycle itself, e.g. the last burst word.
- Simultaneous events:
  - If req drops in the same cycle rempty rises, exit with no pop.
  - If the burst end coincides with an empty FIFO, only the pop decides. No pop means no count increment.
- Fairness:
  - last is updated only at grant, so the next arbitration starts after the most recent winner.
  - A lone requester is re-granted after the one-cycle IDLE gap.
- Width rules:
  - count saturates logically via the exit condition and never wraps.
  - The modulo-NREQ search handles non-power-of-two NREQ.
- Reset mid-SERVE: all outputs return to reset values immediately. A pop in flight on that edge is not issued, because rinc goes low asynchronously.

## Timing
- Arbitration latency:
  - req seen in IDLE at edge N gives gnt high after edge N. The first rinc can occur in cycle N+1.
  - dout_vld for that word occurs in cycle N+2.
- Throughput: one word per cycle within a grant.
- Grant switch: a minimum one-cycle IDLE gap between grants, so a new grant arrives 2 cycles after the previous grant's final pop.
- rinc depends combinationally on req and rempty. Consumers must drive req from flops.
- dout/dout_vld/dout_id lag rinc by exactly one cycle.

## Configuration
- Macro RDARB_BURST_LIMIT_EN.
- Defined: a grant ends after BURST pops; the count register and its exit term are present.
- Undefined: the count register and its exit term are removed and BURST is ignored. A grant lasts until req[owner] drops or rempty rises.

## Test plan
- Reset: assert rrst mid-burst with 3 words queued. Required: gnt=0, rinc=0 and dout_vld=0 immediately. After release with req=0001, grant 0 is reissued first.
- Single consumer: NREQ=4, FIFO holds 0x11,0x22,0x33, req=0001 held. Required:
  - gnt=0001 one cycle after req.
  - rinc high for 3 consecutive cycles.
  - dout 0x11,0x22,0x33 with dout_id=0.
  - After rempty rises, gnt drops and state is IDLE.
- Round robin: req=1111 with FIFO never empty. Required: grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Burst limit (macro defined, BURST=4): req=0011 with 10 words queued. Required: consumer 0 gets 4 words, then consumer 1 gets 4, then consumer 0 gets 2. Without the macro, consumer 0 gets all 10.
- Request drop: req[owner] falls after 2 pops with 5 words left. Required: rinc low in the same cycle, gnt cleared at the next edge, exactly 2 dout_vld pulses.
- Empty gating: req=0100 while rempty=1 for 20 cycles. Required: gnt stays 0 and rinc stays 0. When rempty falls, gnt=0100 follows one cycle later.
